// File: rtl/packer_pkg.sv
// rtl/packer_pkg.sv - shared defaults and helpers for the ratio packer
package packer_pkg;

    localparam int D_WIDTH_DEF = 6;
    localparam int RATIO_DEF   = 4;

    // Lane counter must also represent RATIO itself (reported as a lane count)
    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ratio_packer_outreg.sv
// rtl/ratio_packer_outreg.sv - single-entry output register with valid/ready
module ratio_packer_outreg #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         down_ready,
    output logic [W-1:0] down_data,
    output logic         down_valid,
    output logic         free_or_draining
);

    assign free_or_draining = !down_valid || down_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
        end else if (load) begin
            down_valid <= 1'b1;
            down_data  <= load_data;
        end else if (down_ready) begin
            down_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ratio_packer.sv
// rtl/ratio_packer.sv - packs RATIO narrow beats into one wide word; PACKER_FLUSH_EN adds partial-word flush
module ratio_packer
    import packer_pkg::*;
#(
    parameter  int D_WIDTH = D_WIDTH_DEF,
    parameter  int RATIO   = RATIO_DEF,
    localparam int CNT_W   = cnt_width(RATIO)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [D_WIDTH-1:0]         up_data,
    input  logic                       up_valid,
    output logic                       up_ready,
    output logic [RATIO*D_WIDTH-1:0]   down_data,
    output logic                       down_valid,
`ifdef PACKER_FLUSH_EN
    input  logic                       flush_req,
    output logic [CNT_W-1:0]           down_lanes,
`endif
    input  logic                       down_ready
);

    localparam int                WW       = RATIO * D_WIDTH;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt;
    logic [WW-1:0]    buf_q;
    logic [WW-1:0]    merged;
    logic             free;
    logic             accept;
    logic             emit;

    assign up_ready = (cnt != LAST_CNT) || free;
    assign accept   = up_valid && up_ready;

    always_comb begin
        merged = buf_q;
        if (accept)
            merged[lane_lsb(int'(cnt), D_WIDTH) +: D_WIDTH] = up_data;
    end

`ifdef PACKER_FLUSH_EN
    localparam int OW = WW + CNT_W;
    logic [CNT_W-1:0] filled;
    logic             flush_fire;

    assign filled     = cnt + CNT_W'(accept);
    assign flush_fire = flush_req && (filled != '0) && free;
    assign emit       = (accept && (cnt == LAST_CNT)) || flush_fire;

    logic [OW-1:0] out_word;
    assign {down_lanes, down_data} = out_word;
`else
    localparam int OW = WW;
    logic [OW-1:0] out_word;

    assign emit      = accept && (cnt == LAST_CNT);
    assign down_data = out_word;
`endif

    // Buffer is cleared on emit so a flushed word's unfilled lanes read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            buf_q <= '0;
        end else if (emit) begin
            cnt   <= '0;
            buf_q <= '0;
        end else if (accept) begin
            cnt   <= cnt + CNT_W'(1);
            buf_q <= merged;
        end
    end

    ratio_packer_outreg #(.W(OW)) u_outreg (
        .clk              (clk),
        .rst              (rst),
        .load             (emit),
`ifdef PACKER_FLUSH_EN
        .load_data        ({filled, merged}),
`else
        .load_data        (merged),
`endif
        .down_ready       (down_ready),
        .down_data        (out_word),
        .down_valid       (down_valid),
        .free_or_draining (free)
    );

endmodule
